// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative multiplier and its neighbours in the EX/WB path.
// Holds the FSM encoding and the writeback-select code that routes the product.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } mul_state_t;

  // Writeback mux select for the multiplier result (data11_i input).
  localparam logic [1:0] WB_MUL = 2'b11;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: size BUSY iterations, then a one-cycle DONE with the
// signed/unsigned product on product_hi_o/product_lo_o, which then holds until the next DONE.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int size  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [size-1:0] product_lo_o,
  output logic [size-1:0] product_hi_o,
  output logic [1:0]      state_o
);

  // Handshake: a request is taken on a rising edge where start_i=1 and ready_o=1
  // (IDLE only); start_i at any other time is dropped. valid_o is a single-cycle pulse
  // with no back-pressure; the product stays readable afterwards until the next result.

  mul_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [size-1:0]       mcand_q;
  logic [size-1:0]       mplier_q;
  logic [2*size-1:0]     acc_q;
  logic [2*size-1:0]     prod_q;
  logic                  neg_q;
  logic [size:0]         sum;
  logic [2*size-1:0]     result;

  function automatic logic [size-1:0] magnitude(input logic [size-1:0] v, input logic is_signed);
    magnitude = (is_signed && v[size-1]) ? -v : v;
  endfunction

  function automatic logic [2*size-1:0] apply_sign(input logic [2*size-1:0] v, input logic neg);
    apply_sign = neg ? -v : v;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_BUSY;
      S_BUSY: if (cnt_q == CNT_W'(size - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Carry-preserving add into the upper accumulator half.
  always_comb begin
    sum = {1'b0, acc_q[2*size-1:size]};
    if (mplier_q[0]) sum = sum + {1'b0, mcand_q};
  end

  assign result = apply_sign(acc_q, neg_q);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mcand_q  <= magnitude(src1_i, signed_i);
            mplier_q <= magnitude(src2_i, signed_i);
            neg_q    <= signed_i & (src1_i[size-1] ^ src2_i[size-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          acc_q    <= {sum, acc_q[size-1:1]};
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        S_DONE: prod_q <= result;
        default: ;
      endcase
    end
  end

  // During DONE the fresh result is driven directly; otherwise the held copy.
  assign {product_hi_o, product_lo_o} = (state_q == S_DONE) ? result : prod_q;

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q == S_BUSY) || (state_q == S_DONE);
  assign valid_o = (state_q == S_DONE);
  assign state_o = state_q;

endmodule
